spi_master_wb: RTL and testbench

Parametrised Wishbone-slave SPI master, the next generation of the SPI core the spi_if bench drives.
- Generalised over character length, slave-select count, divider width and all four CPOL/CPHA modes.
- Adds MSB/LSB-first ordering and error termination.
- Sits between the Wishbone bus and the off-chip SPI pins. Port names match spi_if, so the existing bench binds directly.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clkgen.sv | 40 ++++
 rtl/spi_master_wb.sv | 167 ++++++++++++++++
 tb/tb_spi_master_wb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map, CTRL bit positions and FSM states for spi_master_wb
package spi_pkg;

  localparam logic [4:0] ADR_DATA = 5'h00;
  localparam logic [4:0] ADR_CTRL = 5'h04;
  localparam logic [4:0] ADR_DIV  = 5'h08;
  localparam logic [4:0] ADR_SS   = 5'h0C;
  localparam logic [4:0] ADR_STAT = 5'h10;

  localparam int CTRL_GO   = 8;
  localparam int CTRL_CPOL = 9;
  localparam int CTRL_CPHA = 10;
  localparam int CTRL_LSB  = 11;
  localparam int CTRL_IE   = 12;
  localparam int CTRL_ASS  = 13;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = lanes[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SPI clock divider with per-edge strobes
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cpol,
  input  logic [DIV_W-1:0] divider,
  output logic             sclk,
  output logic             pos_edge,
  output logic             neg_edge
);

  logic [DIV_W-1:0] cnt;
  logic             sclk_q;
  logic             tick;

  assign tick     = en && (cnt == '0);
  assign pos_edge = tick & ~sclk_q;
  assign neg_edge = tick &  sclk_q;
  // Outside a transfer the pin follows CPOL directly so a CPOL write shows at once.
  assign sclk     = en ? sclk_q : cpol;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      sclk_q <= 1'b0;
    end else if (!en) begin
      cnt    <= divider;
      sclk_q <= cpol;
    end else if (tick) begin
      cnt    <= divider;
      sclk_q <= ~sclk_q;
    end else begin
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_wb.sv
// rtl/spi_master_wb.sv - Wishbone-slave SPI master, all CPOL/CPHA modes, MSB/LSB first
// Optional SPI_AUTO_SS_EN: CTRL.ASS drives slave selects only while a transfer runs.
module spi_master_wb
  import spi_pkg::*;
#(
  parameter int MAX_CHAR = 32,
  parameter int SS_NB    = 8,
  parameter int DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       adr,
  input  logic [31:0]      dout,
  output logic [31:0]      din,
  input  logic [3:0]       sel,
  input  logic             we,
  input  logic             stb,
  input  logic             cyc,
  output logic             ack,
  output logic             err,
  output logic             intp,
  output logic             transfer_in_progress,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [SS_NB-1:0] ss
);

  localparam int         IW   = (MAX_CHAR > 1) ? $clog2(MAX_CHAR) : 1;
  localparam logic [6:0] MAXC = 7'(MAX_CHAR);

  logic [MAX_CHAR-1:0] tx_reg, rx_reg, rx_sr;
  logic [6:0]          char_len, len_eff, edge_cnt, bit_n, last_edge;
  logic                go, cpol, cpha, lsb, ie, ass;
  logic [DIV_W-1:0]    div_reg;
  logic [SS_NB-1:0]    ss_reg;
  spi_state_e          state, state_nxt;
  logic                req, adr_ok, acc, busy, pos_edge, neg_edge, sclk_edge;
  logic [31:0]         rd_val, old_val, wr_val;

  assign req       = stb & cyc & ~ack & ~err;
  assign adr_ok    = (adr[1:0] == 2'b00) && (adr <= ADR_STAT);
  assign acc       = req & adr_ok;
  assign transfer_in_progress = (state == SHIFT);
  assign busy      = (state != IDLE) | go;
  assign len_eff   = (char_len == 7'd0 || char_len > MAXC) ? MAXC : char_len;
  assign last_edge = {len_eff[5:0], 1'b0} - 7'd1;
  assign bit_n     = {1'b0, edge_cnt[6:1]};
  assign sclk_edge = pos_edge | neg_edge;

  function automatic logic [IW-1:0] bit_pos(input logic [6:0] k);
    return IW'(lsb ? k : (len_eff - 7'd1 - k));
  endfunction

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (transfer_in_progress),
    .cpol     (cpol),
    .divider  (div_reg),
    .sclk     (sclk),
    .pos_edge (pos_edge),
    .neg_edge (neg_edge)
  );

`ifdef SPI_AUTO_SS_EN
  assign ss = (ass && !transfer_in_progress) ? '1 : ~ss_reg;
`else
  assign ass = 1'b0;
  assign ss  = ~ss_reg;
`endif

  always_comb begin
    rd_val  = '0;
    old_val = '0;
    case (adr)
      ADR_DATA: begin rd_val = 32'(rx_reg); old_val = 32'(tx_reg); end
      ADR_CTRL: rd_val = {18'b0, ass, ie, lsb, cpha, cpol, go, 1'b0, char_len};
      ADR_DIV:  rd_val = 32'(div_reg);
      ADR_SS:   rd_val = 32'(ss_reg);
      ADR_STAT: rd_val = {30'b0, intp, transfer_in_progress};
      default:  rd_val = '0;
    endcase
    if (adr != ADR_DATA) old_val = rd_val;
  end

  assign wr_val = merge_bytes(old_val, dout, sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0; err <= 1'b0; din <= '0; intp <= 1'b0;
      tx_reg <= '0; rx_reg <= '0; char_len <= '0; div_reg <= '0; ss_reg <= '0;
      go <= 1'b0; cpol <= 1'b0; cpha <= 1'b0; lsb <= 1'b0; ie <= 1'b0;
`ifdef SPI_AUTO_SS_EN
      ass <= 1'b0;
`endif
    end else begin
      ack <= acc;
      err <= req & ~adr_ok;
      if (req) din <= adr_ok ? rd_val : '0;
      if (acc && we) begin
        case (adr)
          ADR_DATA: if (!busy) tx_reg <= wr_val[MAX_CHAR-1:0];
          ADR_CTRL: if (!busy) begin
            char_len <= wr_val[6:0];
            go       <= wr_val[CTRL_GO];
            cpol     <= wr_val[CTRL_CPOL];
            cpha     <= wr_val[CTRL_CPHA];
            lsb      <= wr_val[CTRL_LSB];
            ie       <= wr_val[CTRL_IE];
`ifdef SPI_AUTO_SS_EN
            ass      <= wr_val[CTRL_ASS];
`endif
          end
          ADR_DIV:  if (!busy) div_reg <= wr_val[DIV_W-1:0];
          ADR_SS:   ss_reg <= wr_val[SS_NB-1:0];
          default:  ;
        endcase
      end
      if (state == DONE) begin
        rx_reg <= rx_sr;
        go     <= 1'b0;
      end
      // A completion in the same cycle as a bus access keeps the interrupt raised.
      if (state == DONE && ie) intp <= 1'b1;
      else if (acc)            intp <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SHIFT;
      SHIFT:   if (sclk_edge && edge_cnt == last_edge) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Even edge counts are leading edges, odd are trailing.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      rx_sr    <= '0;
      mosi     <= 1'b0;
    end else if (state == IDLE && go) begin
      edge_cnt <= '0;
      rx_sr    <= '0;
      if (!cpha) mosi <= tx_reg[bit_pos(7'd0)];
    end else if (state == SHIFT && sclk_edge) begin
      edge_cnt <= edge_cnt + 7'd1;
      if (!edge_cnt[0]) begin
        if (cpha) mosi <= tx_reg[bit_pos(bit_n)];
        else      rx_sr[bit_pos(bit_n)] <= miso;
      end else begin
        if (cpha)                          rx_sr[bit_pos(bit_n)] <= miso;
        else if (bit_n + 7'd1 < len_eff)   mosi <= tx_reg[bit_pos(bit_n + 7'd1)];
      end
    end
  end

endmodule

// File: tb/tb_spi_master_wb.sv
// tb/tb_spi_master_wb.sv - scoreboard bench for spi_master_wb with mosi->miso loopback
module tb_spi_master_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] dout, din;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack, err, intp, tip, sclk, mosi, miso;
  logic [7:0]  ss;

  always #5 clk = ~clk;
  assign miso = mosi;

  spi_master_wb dut (
    .clk(clk), .rst(rst), .adr(adr), .dout(dout), .din(din), .sel(sel),
    .we(we), .stb(stb), .cyc(cyc), .ack(ack), .err(err), .intp(intp),
    .transfer_in_progress(tip), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic handle_resp();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_response: ack=%0b err=%0b expected none", ack, err);
    end else begin
      e = exp_q.pop_front();
      check("resp_kind", {30'b0, ack, err}, e.is_err ? 32'h1 : 32'h2);
      if (e.chk) check("read_data", din, e.data);
    end
  endtask

  logic ack_prev = 1'b0;
  int   dbl_ack  = 0;
  always @(negedge clk) begin
    if (ack || err) handle_resp();
    if (ack && ack_prev) dbl_ack <= dbl_ack + 1;
    ack_prev <= ack;
  end

  logic prev_sclk = 1'b0, tip_d = 1'b0, seen = 1'b0;
  logic mcpol = 1'b0, mcpha = 1'b0;
  int   exp_gap = 1, cyc_cnt = 0, last_cyc = 0, edges = 0, bits = 0, bad_gap = 0;
  logic [31:0] cap = '0;
  logic bitlog[$];

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!tip && !tip_d) begin
      seen <= 1'b0;
    end else if (sclk !== prev_sclk) begin
      if (seen && (cyc_cnt - last_cyc) != exp_gap) bad_gap <= bad_gap + 1;
      seen     <= 1'b1;
      last_cyc <= cyc_cnt;
      edges    <= edges + 1;
      if ((prev_sclk == mcpol) == !mcpha) begin
        cap  <= {cap[30:0], mosi};
        bits <= bits + 1;
        bitlog.push_back(mosi);
      end
    end
    prev_sclk <= sclk;
    tip_d     <= tip;
  end

  task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input logic chk, input logic [31:0] expd,
                     input logic experr);
    exp_t e;
    int   n;
    e.is_err = experr; e.chk = chk; e.data = expd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    adr = a; we = w; dout = d; sel = s; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(ack || err) && n < 8);
    check("ack_latency", n, 1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, 4'hF, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] expd);
    bus(a, 1'b0, 32'h0, 4'hF, 1'b1, expd, 1'b0);
  endtask

  int s_edges, s_bits, s_bad;

  task automatic start_xfer(input logic [31:0] tx, input logic [31:0] ctrl, input int div);
    mcpol   = ctrl[9];
    mcpha   = ctrl[10];
    exp_gap = div + 1;
    wr(5'h08, 32'(div));
    wr(5'h00, tx);
    s_edges = edges; s_bits = bits; s_bad = bad_gap;
    wr(5'h04, ctrl);
    check("tip_in_ack_cycle", {31'b0, tip}, 32'h0);
    @(posedge clk); #1;
    check("tip_rise", {31'b0, tip}, 32'h1);
  endtask

  task automatic finish_xfer(input int len, input logic [31:0] exp_cap,
                             input logic [31:0] exp_rx, input logic exp_first);
    int n;
    logic [31:0] m;
    n = 0;
    while (tip && n < 4000) begin @(posedge clk); #1; n++; end
    check("tip_fall", {31'b0, tip}, 32'h0);
    @(posedge clk); #1;
    m = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    check("edge_count", edges - s_edges, 2 * len);
    check("edge_spacing", bad_gap - s_bad, 0);
    check("mosi_bits", cap & m, exp_cap);
    check("first_bit", {31'b0, (bitlog.size() > s_bits) ? bitlog[s_bits] : 1'bx}, {31'b0, exp_first});
    check("sclk_idle", {31'b0, sclk}, {31'b0, mcpol});
    check("intp_set", {31'b0, intp}, 32'h1);
    rd(5'h10, 32'h2);
    rd(5'h00, exp_rx);
    check("intp_clear", {31'b0, intp}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; adr = '0; dout = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ss", 32'(ss), 32'hFF);
    check("rst_sclk", {31'b0, sclk}, 32'h0);
    check("rst_intp", {31'b0, intp}, 32'h0);
    check("rst_tip", {31'b0, tip}, 32'h0);
    check("rst_mosi", {31'b0, mosi}, 32'h0);
    check("rst_din", din, 32'h0);
    rd(5'h04, 32'h0);
    rd(5'h08, 32'h0);
    rd(5'h0C, 32'h0);
    rd(5'h10, 32'h0);
    rd(5'h00, 32'h0);

    // Mode 0, MSB first, 8 bits
    wr(5'h0C, 32'h1);
    check("ss_written", 32'(ss), 32'hFE);
    start_xfer(32'hA5, 32'h1108, 1);
    finish_xfer(8, 32'hA5, 32'hA5, 1'b1);

    // Modes 1..3, LSB first, 16 bits of 0x0001
    start_xfer(32'h1, 32'h1D10, 1);
    finish_xfer(16, 32'h8000, 32'h1, 1'b1);
    start_xfer(32'h1, 32'h1B10, 2);
    finish_xfer(16, 32'h8000, 32'h1, 1'b1);
    start_xfer(32'h1, 32'h1F10, 0);
    finish_xfer(16, 32'h8000, 32'h1, 1'b1);

    // CHAR_LEN=0 means the full 32 bits
    start_xfer(32'hDEADBEEF, 32'h1100, 0);
    finish_xfer(32, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    rd(5'h04, 32'h1000);

    // Bad addresses terminate with err and leave registers alone
    bus(5'h14, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b1);
    bus(5'h02, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b1);
    bus(5'h0A, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1);
    rd(5'h08, 32'h0);
    rd(5'h0C, 32'h1);
    rd(5'h00, 32'hDEADBEEF);

    // Writes to DATA/DIVIDER/CTRL while busy are ignored
    start_xfer(32'h3C, 32'h1108, 3);
    wr(5'h00, 32'hFF);
    wr(5'h08, 32'h7);
    wr(5'h04, 32'h1104);
    rd(5'h10, 32'h1);
    finish_xfer(8, 32'h3C, 32'h3C, 1'b0);
    rd(5'h08, 32'h3);
    rd(5'h04, 32'h1008);

    // Byte lane merge
    bus(5'h08, 1'b1, 32'h1234_AB56, 4'b0010, 1'b0, 32'h0, 1'b0);
    rd(5'h08, 32'hAB03);

    // Automatic slave select
    wr(5'h0C, 32'h4);
    wr(5'h04, 32'h2000);
`ifdef SPI_AUTO_SS_EN
    check("ass_idle_ss", 32'(ss), 32'hFF);
    rd(5'h04, 32'h2000);
`else
    check("ass_idle_ss", 32'(ss), 32'hFB);
    rd(5'h04, 32'h0);
`endif
    start_xfer(32'h5A, 32'h3108, 1);
    check("ass_busy_ss", 32'(ss), 32'hFB);
    finish_xfer(8, 32'h5A, 32'h5A, 1'b0);
`ifdef SPI_AUTO_SS_EN
    check("ass_after_ss", 32'(ss), 32'hFF);
`else
    check("ass_after_ss", 32'(ss), 32'hFB);
`endif

    // Reset in the middle of a transfer
    start_xfer(32'h96, 32'h1108, 2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ss", 32'(ss), 32'hFF);
    check("midrst_tip", {31'b0, tip}, 32'h0);
    check("midrst_sclk", {31'b0, sclk}, 32'h0);
    check("midrst_mosi", {31'b0, mosi}, 32'h0);
    rst = 1'b0;
    rd(5'h0C, 32'h0);
    rd(5'h04, 32'h0);

    repeat (5) @(posedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("ack_single_cycle", dbl_ack, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
